// File: rtl/rect_draw_pkg.sv
// Shared definitions for the rectangle drawer: FSM encoding, draw modes and
// the clamp applied to the runtime width/height inputs.
package rect_draw_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  // Zero means a single pixel; anything beyond the maximum is limited to it.
  function automatic int unsigned clamp_dim(input int unsigned v, input int unsigned max_v);
    if (v == 0) return 1;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major 2-D scan counter: px runs 0..w_lim-1, then wraps with py+1.
// last flags the final (px, py) position of the rectangle.
module rect_scan_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] w_lim,
  input  logic [CNT_W-1:0] h_lim,
  output logic [CNT_W-1:0] px,
  output logic [CNT_W-1:0] py,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic col_end;

  assign col_end = (px == w_lim - ONE);
  assign last    = col_end && (py == h_lim - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= '0;
      py <= '0;
    end else if (clear) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (col_end) begin
        px <= '0;
        py <= py + ONE;
      end else begin
        px <= px + ONE;
      end
    end
  end

endmodule

// File: rtl/rect_drawer.sv
// Rectangle drawer: emits one registered pixel per clock in row-major order,
// with optional outline masking and off-screen clipping.
module rect_drawer
  import rect_draw_pkg::*;
#(
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned CW       = 3,
  parameter int unsigned MAX_W    = 16,
  parameter int unsigned MAX_H    = 16,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  localparam int unsigned WW      = $clog2(MAX_W) + 1,
  localparam int unsigned HW      = $clog2(MAX_H) + 1
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          go,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  input  logic [WW-1:0] w_in,
  input  logic [HW-1:0] h_in,
  input  logic [CW-1:0] colour,
  input  logic          outline,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] c,
  output logic          writeEn,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CNT_W = (WW > HW) ? WW : HW;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [XW-1:0]    x_org;
  logic [YW-1:0]    y_org;
  logic [CW-1:0]    c_org;
  logic             outline_r;
  logic [WW-1:0]    w_org;
  logic [HW-1:0]    h_org;
  logic             issued;

  logic [CNT_W-1:0] w_lim, h_lim, px, py;
  logic             last, start, step;
  logic [XW:0]      xs;
  logic [YW:0]      ys;
  logic             clipped, masked;

  assign w_lim = CNT_W'(w_org);
  assign h_lim = CNT_W'(h_org);
  assign start = (state == S_IDLE) && go;
  assign step  = (state == S_DRAW) && !issued;

  rect_scan_counter #(.CNT_W(CNT_W)) u_scan (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .clear (start),
    .en    (step),
    .w_lim (w_lim),
    .h_lim (h_lim),
    .px    (px),
    .py    (py),
    .last  (last)
  );

  // One bit wider than the coordinate so an origin near the edge cannot wrap back on-screen.
  assign xs      = (XW+1)'(x_org) + (XW+1)'(px);
  assign ys      = (YW+1)'(y_org) + (YW+1)'(py);
  assign clipped = (xs >= (XW+1)'(SCREEN_W)) || (ys >= (YW+1)'(SCREEN_H));
  assign masked  = (outline_r == MODE_OUTLINE) &&
                   (px != '0) && (px != w_lim - ONE) &&
                   (py != '0) && (py != h_lim - ONE);

  // issued marks that the final pixel went out, giving one drain edge before DONE.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      c         <= '0;
      writeEn   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_org     <= '0;
      y_org     <= '0;
      c_org     <= '0;
      outline_r <= MODE_FILL;
      w_org     <= '0;
      h_org     <= '0;
      issued    <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            x_org     <= x_in;
            y_org     <= y_in;
            c_org     <= colour;
            outline_r <= outline;
            w_org     <= WW'(clamp_dim(int'(w_in), MAX_W));
            h_org     <= HW'(clamp_dim(int'(h_in), MAX_H));
            issued    <= 1'b0;
            busy      <= 1'b1;
            state     <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (issued) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            x       <= xs[XW-1:0];
            y       <= ys[YW-1:0];
            c       <= c_org;
            writeEn <= !clipped && !masked;
            if (last) issued <= 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_drawer.sv
// Scoreboard bench for rect_drawer: stimulus queues expected writes/done times
// from a direct geometric model; a negedge monitor pops and compares.
module tb_rect_drawer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b1;
  logic       go       = 1'b0;
  logic [7:0] x_in     = '0;
  logic [6:0] y_in     = '0;
  logic [4:0] w_in     = '0;
  logic [4:0] h_in     = '0;
  logic [2:0] colour   = '0;
  logic       outline  = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] c;
  logic       writeEn, busy, done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    int xx;
    int yy;
    int cc;
    int at;
  } pix_t;

  pix_t pix_q[$];
  int   done_q[$];

  rect_drawer dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .go       (go),
    .x_in     (x_in),
    .y_in     (y_in),
    .w_in     (w_in),
    .h_in     (h_in),
    .colour   (colour),
    .outline  (outline),
    .x        (x),
    .y        (y),
    .c        (c),
    .writeEn  (writeEn),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge CLOCK_50) begin
    if (resetn) begin
      if (writeEn) begin
        if (pix_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          pix_t p;
          p = pix_q.pop_front();
          check("pix_x", int'(x), p.xx);
          check("pix_y", int'(y), p.yy);
          check("pix_c", int'(c), p.cc);
          check("pix_cycle", cyc, p.at);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          int e;
          e = done_q.pop_front();
          check("done_cycle", cyc, e);
          check("busy_at_done", int'(busy), 1);
        end
      end
    end
  end

  function automatic int clampd(input int v);
    return (v == 0) ? 1 : ((v > 16) ? 16 : v);
  endfunction

  // Queue every visible pixel of the rectangle with the cycle it should appear.
  task automatic expect_rect(input int xo, input int yo, input int w, input int h,
                             input int col, input int ol, input int e0);
    int we, he, idx;
    pix_t p;
    we  = clampd(w);
    he  = clampd(h);
    idx = 0;
    for (int r = 0; r < he; r++) begin
      for (int q = 0; q < we; q++) begin
        bit border;
        border = (r == 0) || (r == he - 1) || (q == 0) || (q == we - 1);
        idx++;
        if ((xo + q) < 160 && (yo + r) < 120 && (ol == 0 || border)) begin
          p.xx = xo + q;
          p.yy = yo + r;
          p.cc = col;
          p.at = e0 + idx;
          pix_q.push_back(p);
        end
      end
    end
    done_q.push_back(e0 + we * he + 1);
  endtask

  task automatic apply(input int xo, input int yo, input int w, input int h,
                       input int col, input int ol);
    x_in    = 8'(xo);
    y_in    = 7'(yo);
    w_in    = 5'(w);
    h_in    = 5'(h);
    colour  = 3'(col);
    outline = ol[0];
    go      = 1'b1;
  endtask

  task automatic draw(input int xo, input int yo, input int w, input int h,
                      input int col, input int ol, input bit pulse);
    int n, e0;
    @(negedge CLOCK_50);
    apply(xo, yo, w, h, col, ol);
    e0 = cyc + 1;
    n  = clampd(w) * clampd(h);
    expect_rect(xo, yo, w, h, col, ol, e0);
    @(negedge CLOCK_50);
    check("busy_after_go", int'(busy), 1);
    go      = 1'b0;
    x_in    = 8'($urandom);
    y_in    = 7'($urandom);
    w_in    = 5'($urandom);
    h_in    = 5'($urandom);
    colour  = 3'($urandom);
    outline = 1'($urandom);
    for (int t = 0; t < 400; t++) begin
      if (!busy) break;
      @(negedge CLOCK_50);
      go = pulse && (cyc == e0 + 3 || cyc == e0 + n + 1) && (cyc < e0 + n + 2);
    end
    go = 1'b0;
    check("busy_low", int'(busy), 0);
    check("idle_cycle", cyc, e0 + n + 2);
    check("writes_left", pix_q.size(), 0);
    check("done_left", done_q.size(), 0);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1 check("reset_outputs", int'({x, y, c, writeEn, busy, done}), 0);
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;

    draw(10, 20, 4, 4, 3'b100, 0, 1'b0);
    draw(0, 0, 4, 3, 2, 1, 1'b0);
    draw(158, 118, 4, 4, 7, 0, 1'b0);
    draw(5, 6, 0, 0, 1, 0, 1'b0);
    draw(50, 60, 31, 1, 6, 0, 1'b0);
    draw(3, 4, 1, 5, 2, 1, 1'b0);
    draw(20, 30, 4, 4, 3, 0, 1'b1);

    // Abort a 16-pixel fill after its fifth pixel.
    begin
      int e0;
      @(negedge CLOCK_50);
      apply(30, 40, 4, 4, 5, 0);
      e0 = cyc + 1;
      expect_rect(30, 40, 4, 4, 5, 0, e0);
      @(negedge CLOCK_50);
      go = 1'b0;
      for (int t = 0; t < 50; t++) begin
        if (cyc >= e0 + 5) break;
        @(negedge CLOCK_50);
      end
      resetn = 1'b0;
      #1 check("abort_outputs", int'({x, y, c, writeEn, busy, done}), 0);
      pix_q.delete();
      done_q.delete();
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;
    end
    draw(30, 40, 4, 4, 5, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge CLOCK_50);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
